// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA mode controller: mode codes, timing record,
// mode table and FSM state encoding.
package vga_pkg;

    localparam logic [3:0] MODE_640X480  = 4'd0;
    localparam logic [3:0] MODE_800X600  = 4'd1;
    localparam logic [3:0] MODE_1024X768 = 4'd2;
    localparam logic [3:0] MODE_1280X720 = 4'd3;

    typedef struct packed {
        logic [11:0] h_active;
        logic [11:0] h_fp;
        logic [11:0] h_sync;
        logic [11:0] h_bp;
        logic [11:0] v_active;
        logic [11:0] v_fp;
        logic [11:0] v_sync;
        logic [11:0] v_bp;
        logic        hsync_neg;
        logic        vsync_neg;
    } vga_timing_t;

    localparam vga_timing_t TIMING_640X480 = '{
        h_active: 12'd640,  h_fp: 12'd16,  h_sync: 12'd96,  h_bp: 12'd48,
        v_active: 12'd480,  v_fp: 12'd10,  v_sync: 12'd2,   v_bp: 12'd33,
        hsync_neg: 1'b1, vsync_neg: 1'b1};
    localparam vga_timing_t TIMING_800X600 = '{
        h_active: 12'd800,  h_fp: 12'd40,  h_sync: 12'd128, h_bp: 12'd88,
        v_active: 12'd600,  v_fp: 12'd1,   v_sync: 12'd4,   v_bp: 12'd23,
        hsync_neg: 1'b0, vsync_neg: 1'b0};
    localparam vga_timing_t TIMING_1024X768 = '{
        h_active: 12'd1024, h_fp: 12'd24,  h_sync: 12'd136, h_bp: 12'd160,
        v_active: 12'd768,  v_fp: 12'd3,   v_sync: 12'd6,   v_bp: 12'd29,
        hsync_neg: 1'b1, vsync_neg: 1'b1};
    localparam vga_timing_t TIMING_1280X720 = '{
        h_active: 12'd1280, h_fp: 12'd110, h_sync: 12'd40,  h_bp: 12'd220,
        v_active: 12'd720,  v_fp: 12'd5,   v_sync: 12'd5,   v_bp: 12'd20,
        hsync_neg: 1'b0, vsync_neg: 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_BLANK      = 2'd2,
        ST_SETTLE     = 2'd3
    } vga_state_t;

    function automatic logic mode_supported(input logic [3:0] m);
        return (m <= MODE_1280X720);
    endfunction

    // Unsupported codes fall back to 640x480 so reset can never load garbage.
    function automatic vga_timing_t timing_of(input logic [3:0] m);
        case (m)
            MODE_800X600:  return TIMING_800X600;
            MODE_1024X768: return TIMING_1024X768;
            MODE_1280X720: return TIMING_1280X720;
            default:       return TIMING_640X480;
        endcase
    endfunction

endpackage

// File: rtl/vga_mode_rom.sv
// Combinational mode -> timing record lookup with a supported-mode flag.
module vga_mode_rom
    import vga_pkg::*;
(
    input  logic [3:0]  i_mode,
    output vga_timing_t o_timing,
    output logic        o_valid
);

    always_comb begin
        o_timing = timing_of(i_mode);
        o_valid  = mode_supported(i_mode);
    end

endmodule

// File: rtl/vga_mode_ctrl.sv
// VGA mode-change sequencer: accepts mode requests, blanks and restarts the sync generator
// at a frame boundary, then applies the new timing. Optional settle phase: VGA_MODE_CTRL_SETTLE_EN.
//
// state      | meaning
// IDLE       | ready for a request; current timing applied
// WAIT_FRAME | valid change accepted, waiting for frame_end
// BLANK      | one cycle: blank + sync restart, new timing loads on exit
// SETTLE     | blanked for SETTLE_FRAMES frames before completing
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter logic [3:0] DEFAULT_MODE  = 4'd0,
    parameter int         SETTLE_FRAMES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_req_mode,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_frame_end,
    output logic        o_done,
    output logic        o_err,
    output logic [3:0]  o_mode,
    output logic [11:0] o_h_active,
    output logic [11:0] o_h_fp,
    output logic [11:0] o_h_sync,
    output logic [11:0] o_h_bp,
    output logic [11:0] o_v_active,
    output logic [11:0] o_v_fp,
    output logic [11:0] o_v_sync,
    output logic [11:0] o_v_bp,
    output logic        o_hsync_neg,
    output logic        o_vsync_neg,
    output logic        o_sync_rst,
    output logic        o_blank
);

    if (SETTLE_FRAMES < 1 || SETTLE_FRAMES > 15) begin : g_bad_settle
        $error("SETTLE_FRAMES must be in 1..15");
    end

    vga_state_t  r_state;
    vga_state_t  w_state_nxt;
    logic [3:0]  r_mode;
    logic [3:0]  r_req_mode;
    vga_timing_t r_timing;
    logic        r_done;
    logic        r_err;

    logic [3:0]  w_rom_mode;
    vga_timing_t w_rom_timing;
    logic        w_rom_valid;
    logic        w_load;
    logic        w_done;
    logic        w_err;

    // While idle the ROM validates the incoming request; afterwards it serves the latched one.
    assign w_rom_mode = (r_state == ST_IDLE) ? i_req_mode : r_req_mode;

    vga_mode_rom u_rom (
        .i_mode   (w_rom_mode),
        .o_timing (w_rom_timing),
        .o_valid  (w_rom_valid)
    );

`ifdef VGA_MODE_CTRL_SETTLE_EN
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_FRAMES);
    logic [3:0] r_settle_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_settle_cnt <= 4'd0;
        end else if (w_load) begin
            r_settle_cnt <= SETTLE_LOAD;
        end else if (r_state == ST_SETTLE && i_frame_end) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (!w_rom_valid) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                    end else if (i_req_mode == r_mode) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_FRAME;
                    end
                end
            end
            ST_WAIT_FRAME: begin
                if (i_frame_end) begin
                    w_state_nxt = ST_BLANK;
                end
            end
            ST_BLANK: begin
                w_load = 1'b1;
`ifdef VGA_MODE_CTRL_SETTLE_EN
                w_state_nxt = ST_SETTLE;
`else
                w_state_nxt = ST_IDLE;
                w_done      = 1'b1;
`endif
            end
`ifdef VGA_MODE_CTRL_SETTLE_EN
            ST_SETTLE: begin
                if (i_frame_end && r_settle_cnt == 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode     <= DEFAULT_MODE;
            r_req_mode <= DEFAULT_MODE;
            r_timing   <= timing_of(DEFAULT_MODE);
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_done;
            r_err  <= w_err;
            if (r_state == ST_IDLE && i_req_valid) begin
                r_req_mode <= i_req_mode;
            end
            if (w_load) begin
                r_mode   <= r_req_mode;
                r_timing <= w_rom_timing;
            end
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_mode      = r_mode;
    assign o_h_active  = r_timing.h_active;
    assign o_h_fp      = r_timing.h_fp;
    assign o_h_sync    = r_timing.h_sync;
    assign o_h_bp      = r_timing.h_bp;
    assign o_v_active  = r_timing.v_active;
    assign o_v_fp      = r_timing.v_fp;
    assign o_v_sync    = r_timing.v_sync;
    assign o_v_bp      = r_timing.v_bp;
    assign o_hsync_neg = r_timing.hsync_neg;
    assign o_vsync_neg = r_timing.vsync_neg;
    assign o_sync_rst  = (r_state == ST_BLANK);
    assign o_blank     = (r_state == ST_BLANK) || (r_state == ST_SETTLE);

endmodule

// File: doc/vga_mode_ctrl.md
VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

Interface
REQ-001 Parameter: DEFAULT_MODE, 4'd0, mode loaded by reset.
REQ-002 Parameter: SETTLE_FRAMES, 2, frames of forced blanking after a mode change (range 1..15).
REQ-003 Port: clk  in  1  single system/pixel clock; all logic on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: req_mode  in  4  requested video mode.
REQ-006 Port: req_valid  in  1  mode request present; held until accepted.
REQ-007 Port: req_ready  out  1  controller able to accept a request.
REQ-008 Port: frame_end  in  1  one-cycle pulse from the sync generator at the last pixel of a frame.
REQ-009 Port: done  out  1  one-cycle completion pulse per accepted request.
REQ-010 Port: err  out  1  qualifies done; 1 means the request was rejected.
REQ-011 Port: mode  out  4  currently applied mode (drives the counter's mode input).
REQ-012 Port: h_active, h_fp, h_sync, h_bp  out  12 each  horizontal timing in pixels.
REQ-013 Port: v_active, v_fp, v_sync, v_bp  out  12 each  vertical timing in lines.
REQ-014 Port: hsync_neg, vsync_neg  out  1 each  1 = sync pulse active-low for the mode.
REQ-015 Port: sync_rst  out  1  synchronous restart strobe to the sync generator.
REQ-016 Port: blank  out  1  forces RGB to zero.

Function
REQ-017 Supported modes (active/fp/sync/bp, H then V), polarity: 0 = 640/16/96/48, 480/10/2/33, neg/neg; 1 = 800/40/128/88, 600/1/4/23, pos/pos; 2 = 1024/24/136/160, 768/3/6/29, neg/neg; 3 = 1280/110/40/220, 720/5/5/20, pos/pos.
REQ-018 FSM states: IDLE, WAIT_FRAME, BLANK, SETTLE; req_ready = 1 only in IDLE.
REQ-019 Request accepted on the cycle with req_valid && req_ready; req_mode latched at that edge.
REQ-020 Unsupported mode (4..15): next cycle done=1, err=1; remain IDLE; outputs unchanged.
REQ-021 Mode equal to current: next cycle done=1, err=0; remain IDLE; no blanking.
REQ-022 Otherwise: IDLE -> WAIT_FRAME on the cycle after acceptance.
REQ-023 WAIT_FRAME: on frame_end sampled high, go to BLANK; blank=1 and sync_rst=1 for exactly the BLANK cycle.
REQ-024 Timing outputs, mode and polarity update at the edge leaving BLANK; all fields change atomically.
REQ-025 blank stays 1 from BLANK through the end of SETTLE.
REQ-026 SETTLE counts frame_end pulses; after the SETTLE_FRAMES-th pulse go to IDLE, with blank=0 and done=1, err=0 in the first IDLE cycle.
REQ-027 frame_end during IDLE or BLANK is ignored; frame_end never arrives in the cycle directly after sync_rst.
REQ-028 done never coincides with req_ready for a newly presented request; back-to-back requests are accepted on the done cycle at the earliest.
REQ-029 Timing outputs are registered (no combinational path from req_mode).

Reset
REQ-030 rst low, at any time including mid-change, asynchronously forces: state IDLE, mode=DEFAULT_MODE with its table timing and polarity, blank=0, sync_rst=0, done=0, err=0, settle counter 0.
REQ-031 req_ready=1 from the first edge after rst deasserts.

Configuration
REQ-032 Macro VGA_MODE_CTRL_SETTLE_EN: when defined, SETTLE behaves per REQ-025/026.
REQ-033 Without VGA_MODE_CTRL_SETTLE_EN: no SETTLE state and no counter; BLANK -> IDLE, done=1 and blank=0 in the cycle new timing first appears; SETTLE_FRAMES unused.

Structure
REQ-034 Shared package vga_pkg holds: mode code constants, a timing record type (eight 12-bit fields plus two polarity bits), the mode table constants, and the FSM state enum.
REQ-035 Sub-module vga_mode_rom: combinational mode -> timing record lookup with a valid flag; instantiated once.

Verification
REQ-036 Reset with DEFAULT_MODE=0 -> mode=0, h_active=640, v_bp=33, hsync_neg=1, blank=0, req_ready=1.
REQ-037 Request mode 1, frame_end 5 cycles later, SETTLE_FRAMES=2 -> sync_rst one cycle, h_active=800 next cycle, blank high until the 2nd later frame_end, then done=1, err=0.
REQ-038 Request mode 9 -> done=1, err=1 one cycle after acceptance; mode stays 0; blank never asserts.
REQ-039 Request mode 0 while in mode 0 -> done=1, err=0 next cycle; no sync_rst.
REQ-040 rst low during SETTLE of a 0->3 change -> immediately mode=0, h_active=640, blank=0; req_ready=1 after release.
REQ-041 req_valid held with mode 2 during WAIT_FRAME of another request -> not accepted until the done cycle; then full sequence completes with h_active=1024.
